// File: rtl/acoustic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acoustic_pkg
// Description : Shared types and constants for the acoustic correlation path:
//               peak-finder FSM encoding and frame/lag sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package acoustic_pkg;

  // Peak-finder FSM encoding, explicit 2-bit width
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } xcorr_state_e;

  // Samples per channel per frame
  localparam int C_SEQUENCE_LENGTH = 512;

  // Number of lags a full correlator sweep produces
  localparam int C_LAG_COUNT = 2 * C_SEQUENCE_LENGTH - 1;

  // Lag count for an arbitrary sequence length
  function automatic int lag_count(input int seq_len);
    return 2 * seq_len - 1;
  endfunction

endpackage : acoustic_pkg
`default_nettype wire

// File: rtl/xcorr_peak.sv
`default_nettype none
// ============================================================================
// Module      : xcorr_peak
// Description : Scans one correlator sweep for its signed maximum, capturing
//               the lag of the peak, its two neighbours and a frame-fault
//               flag; reports the result with a one-cycle peak_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module xcorr_peak
  import acoustic_pkg::*;
#(
  parameter int DATAWIDTH       = 24,
  parameter int SEQUENCE_LENGTH = C_SEQUENCE_LENGTH,
  parameter int LAG_WIDTH       = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          xc_valid,
  input  logic signed [2*DATAWIDTH-1:0] xc_result,
  input  logic        [LAG_WIDTH-1:0]   xc_lag,
  input  logic                          xc_complete,
  output logic                          busy,
  output logic                          peak_valid,
  output logic        [LAG_WIDTH-1:0]   peak_lag,
  output logic signed [2*DATAWIDTH-1:0] peak_value,
  output logic signed [2*DATAWIDTH-1:0] peak_prev,
  output logic signed [2*DATAWIDTH-1:0] peak_next,
  output logic                          peak_err
);

  localparam int XW = 2 * DATAWIDTH;

  // Sample count a clean sweep must end on
  localparam logic [LAG_WIDTH-1:0] c_lag_total = LAG_WIDTH'(lag_count(SEQUENCE_LENGTH));
  // Seed for the running maximum so any real sample can replace it
  localparam logic signed [XW-1:0] c_max_neg   = {1'b1, {(XW-1){1'b0}}};

  xcorr_state_e r_state;
  xcorr_state_e w_state_nxt;

  logic signed [XW-1:0]        r_max;
  logic signed [XW-1:0]        r_prev;
  logic signed [XW-1:0]        r_next;
  logic signed [XW-1:0]        r_last;
  logic        [LAG_WIDTH-1:0] r_lag;
  logic        [LAG_WIDTH-1:0] r_count;
  logic                        r_err;
  logic                        r_pending;

  logic                        w_take;
  logic                        w_done;
  logic                        w_new_max;
  logic                        w_sat;
  logic                        w_pending_nxt;
  logic        [LAG_WIDTH-1:0] w_count_nxt;

  // A start pulse in any state re-arms the scan, so it masks sample and
  // completion handling in the same cycle (abort has priority).
  assign w_take        = (r_state == SCAN) && xc_valid && !start;
  assign w_done        = (r_state == SCAN) && xc_complete && !start;
  assign w_new_max     = w_take && (xc_result > r_max);
  assign w_sat         = (r_count == {LAG_WIDTH{1'b1}});
  assign w_count_nxt   = (w_take && !w_sat) ? r_count + LAG_WIDTH'(1) : r_count;
  // A new maximum arms the neighbour capture; any other sample satisfies it
  assign w_pending_nxt = w_new_max ? 1'b1 : (w_take ? 1'b0 : r_pending);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    peak_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (start)            w_state_nxt = SCAN;
        else if (xc_complete) w_state_nxt = REPORT;
      end
      REPORT: begin
        peak_valid  = 1'b1;
        w_state_nxt = start ? SCAN : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Running maximum, neighbour capture, sample counter and fault tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max     <= '0;
      r_prev    <= '0;
      r_next    <= '0;
      r_last    <= '0;
      r_lag     <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_pending <= 1'b0;
    end else if (start) begin
      r_max     <= c_max_neg;
      r_prev    <= '0;
      r_next    <= '0;
      r_last    <= '0;
      r_lag     <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_take) begin
        r_count   <= w_count_nxt;
        r_last    <= xc_result;
        r_pending <= w_pending_nxt;
        if ((xc_lag != r_count) || w_sat) begin
          r_err <= 1'b1;
        end
        // Strictly greater only, so the lowest lag wins a tie
        if (w_new_max) begin
          r_max  <= xc_result;
          r_lag  <= xc_lag;
          r_prev <= r_last;
        end else if (r_pending) begin
          r_next <= xc_result;
        end
      end
      // Completion sees the count including a coincident final sample
      if (w_done) begin
        if (w_count_nxt != c_lag_total) begin
          r_err <= 1'b1;
        end
        if (w_pending_nxt) begin
          r_next <= '0;
        end
      end
    end
  end

  assign peak_lag   = r_lag;
  assign peak_value = r_max;
  assign peak_prev  = r_prev;
  assign peak_next  = r_next;
  assign peak_err   = r_err;

endmodule : xcorr_peak
`default_nettype wire

// File: tb/tb_xcorr_peak.sv
`default_nettype none
// ============================================================================
// Module      : tb_xcorr_peak
// Description : Self-checking bench for xcorr_peak. Frames are driven from a
//               value table; a reference model pushes the expected report to
//               a scoreboard, popped when peak_valid fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xcorr_peak;

  localparam int DW   = 24;
  localparam int SL   = 512;
  localparam int LW   = 12;
  localparam int XW   = 2 * DW;
  localparam int NLAG = 2 * SL - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 xc_valid;
  logic signed [XW-1:0] xc_result;
  logic        [LW-1:0] xc_lag;
  logic                 xc_complete;
  logic                 busy;
  logic                 peak_valid;
  logic        [LW-1:0] peak_lag;
  logic signed [XW-1:0] peak_value;
  logic signed [XW-1:0] peak_prev;
  logic signed [XW-1:0] peak_next;
  logic                 peak_err;

  xcorr_peak #(
    .DATAWIDTH       (DW),
    .SEQUENCE_LENGTH (SL),
    .LAG_WIDTH       (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .xc_valid    (xc_valid),
    .xc_result   (xc_result),
    .xc_lag      (xc_lag),
    .xc_complete (xc_complete),
    .busy        (busy),
    .peak_valid  (peak_valid),
    .peak_lag    (peak_lag),
    .peak_value  (peak_value),
    .peak_prev   (peak_prev),
    .peak_next   (peak_next),
    .peak_err    (peak_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint lag;
    longint value;
    longint prev;
    longint next;
    longint err;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  int     vals[0:1023];
  int     n_chk = 0;
  int     n_err = 0;
  int     n_pv  = 0;
  int     cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every peak_valid must match a pushed expectation
  always @(negedge clk) begin
    if (rst_n && peak_valid) begin
      n_pv++;
      if (sb.size() == 0) begin
        check("unexpected_peak_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("peak_lag",   longint'(peak_lag), e.lag);
        check("peak_value", longint'(peak_value), e.value);
        check("peak_prev",  longint'(peak_prev), e.prev);
        check("peak_next",  longint'(peak_next), e.next);
        check("peak_err",   longint'(peak_err), e.err);
        check("latency",    longint'(cyc), longint'(e.cyc));
        check("busy_report", longint'(busy), 0);
      end
    end
  end

  // Reference model over the value table: strictly-greater maximum,
  // neighbours by sample order, fault on short frame or skipped lag.
  function automatic exp_t model(input int n, input int skip);
    exp_t   e;
    int     best = 0;
    for (int i = 1; i < n; i++) begin
      if (vals[i] > vals[best]) best = i;
    end
    e.lag   = (skip >= 0 && best >= skip) ? best + 1 : best;
    e.value = vals[best];
    e.prev  = (best > 0) ? vals[best-1] : 0;
    e.next  = (best < n - 1) ? vals[best+1] : 0;
    e.err   = (n != NLAG || skip >= 0) ? 1 : 0;
    e.cyc   = 0;
    return e;
  endfunction

  // Drive one frame; finish=0 leaves it open (abort/reset cases),
  // together=1 raises xc_complete alongside the last sample.
  task automatic send_frame(input int n, input int skip, input bit together,
                            input bit finish, input bit push);
    exp_t e;
    e = model(n, skip);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_scan", longint'(busy), 1);
    for (int i = 0; i < n; i++) begin
      xc_valid  = 1'b1;
      xc_result = XW'(vals[i]);
      xc_lag    = LW'((skip >= 0 && i >= skip) ? i + 1 : i);
      if (finish && together && i == n - 1) begin
        xc_complete = 1'b1;
        e.cyc = cyc + 1;
        if (push) sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    xc_valid    = 1'b0;
    xc_complete = 1'b0;
    if (finish && !together) begin
      xc_complete = 1'b1;
      e.cyc = cyc + 1;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      xc_complete = 1'b0;
    end
  endtask

  // Bounded wait for all expected reports to arrive
  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", longint'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 1024; i++) vals[i] = v;
  endtask

  initial begin
    int pv0;
    rst_n = 1'b0; start = 1'b0; xc_valid = 1'b0;
    xc_result = '0; xc_lag = '0; xc_complete = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  longint'(busy), 0);
    check("rst_valid", longint'(peak_valid), 0);
    check("rst_lag",   longint'(peak_lag), 0);
    check("rst_value", longint'(peak_value), 0);
    check("rst_err",   longint'(peak_err), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single peak with both neighbours
    fill(0); vals[510] = 5; vals[511] = 100; vals[512] = 7;
    send_frame(NLAG, -1, 1'b0, 1'b1, 1'b1);
    drain();

    // Tie keeps lowest lag; first-sample peak has prev 0
    fill(-10); vals[0] = 50; vals[700] = 50;
    send_frame(NLAG, -1, 1'b0, 1'b1, 1'b1);
    drain();

    // Peak on last lag, complete coincident with last sample
    fill(-1); vals[1022] = 1;
    send_frame(NLAG, -1, 1'b1, 1'b1, 1'b1);
    drain();

    // Short frame
    fill(3); vals[20] = 9;
    send_frame(1000, -1, 1'b0, 1'b1, 1'b1);
    drain();

    // Skipped lag 300
    fill(0); vals[600] = 42;
    send_frame(NLAG, 300, 1'b0, 1'b1, 1'b1);
    drain();

    // Abort at sample 400, then a clean frame: one report only
    pv0 = n_pv;
    fill(1000);
    send_frame(400, -1, 1'b0, 1'b0, 1'b0);
    fill(0); vals[100] = -4; vals[101] = 77; vals[102] = 6;
    send_frame(NLAG, -1, 1'b0, 1'b1, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    check("abort_pulses", longint'(n_pv - pv0), 1);

    // Idle traffic is ignored and results hold
    pv0 = n_pv;
    for (int i = 0; i < 6; i++) begin
      xc_valid = 1'b1; xc_result = XW'(5000); xc_lag = LW'(i);
      xc_complete = (i == 3);
      @(posedge clk); #1;
    end
    xc_valid = 1'b0; xc_complete = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("idle_busy",  longint'(busy), 0);
    check("idle_hold",  longint'(peak_value), 77);
    check("idle_pulses", longint'(n_pv - pv0), 0);

    // Reset mid-scan: outputs clear at once, frame discarded
    fill(0); vals[511] = 100;
    send_frame(600, -1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_busy", longint'(busy), 1);
    pv0 = n_pv;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  longint'(busy), 0);
    check("mid_rst_valid", longint'(peak_valid), 0);
    check("mid_rst_lag",   longint'(peak_lag), 0);
    check("mid_rst_value", longint'(peak_value), 0);
    check("mid_rst_prev",  longint'(peak_prev), 0);
    check("mid_rst_next",  longint'(peak_next), 0);
    check("mid_rst_err",   longint'(peak_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    xc_complete = 1'b1;
    @(posedge clk); #1;
    xc_complete = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("post_rst_pulses", longint'(n_pv - pv0), 0);
    check("post_rst_busy",   longint'(busy), 0);
    check("sb_empty",        longint'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_xcorr_peak
`default_nettype wire
